// File: rtl/serial_link_tx_streamer_pkg.sv
// rtl/serial_link_tx_streamer_pkg.sv - shared constants, FSM state and default bus structs for the TX streamer
package serial_link_tx_streamer_pkg;

  localparam int unsigned SL_ADDR_W = 32;
  localparam int unsigned SL_DATA_W = 32;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_DST_ADDR = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_INCR    = 1;
  localparam int unsigned CTRL_ERR_CLR = 2;

  localparam int unsigned STATUS_CNT_LSB  = 0;
  localparam int unsigned STATUS_CNT_MSB  = 7;
  localparam int unsigned STATUS_OUT_LSB  = 8;
  localparam int unsigned STATUS_OUT_MSB  = 15;
  localparam int unsigned STATUS_ERR_LSB  = 16;
  localparam int unsigned STATUS_ERR_MSB  = 23;
  localparam int unsigned STATUS_BUSY_BIT = 24;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {IDLE, SEND} state_e;

  typedef struct packed {
    logic                 req;
    logic [SL_ADDR_W-1:0] addr;
    logic                 we;
    logic [3:0]           be;
    logic [SL_DATA_W-1:0] wdata;
  } sl_obi_req_t;

  typedef struct packed {
    logic                 gnt;
    logic                 rvalid;
    logic [SL_DATA_W-1:0] rdata;
  } sl_obi_resp_t;

  typedef struct packed {
    logic [3:0]           id;
    logic [SL_ADDR_W-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } sl_axi_ax_t;

  typedef struct packed {
    logic [SL_DATA_W-1:0] data;
    logic [3:0]           strb;
    logic                 last;
  } sl_axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } sl_axi_b_t;

  typedef struct packed {
    logic [3:0]           id;
    logic [SL_DATA_W-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } sl_axi_r_t;

  typedef struct packed {
    sl_axi_ax_t aw;
    logic       aw_valid;
    sl_axi_w_t  w;
    logic       w_valid;
    logic       b_ready;
    sl_axi_ax_t ar;
    logic       ar_valid;
    logic       r_ready;
  } sl_axi_req_t;

  typedef struct packed {
    logic      aw_ready;
    logic      ar_ready;
    logic      w_ready;
    logic      b_valid;
    sl_axi_b_t b;
    logic      r_valid;
    sl_axi_r_t r;
  } sl_axi_rsp_t;

  function automatic logic [31:0] pack_status(input logic [7:0] cnt, input logic [7:0] outstanding,
                                              input logic [7:0] err_cnt, input logic busy);
    logic [31:0] s;
    s = '0;
    s[STATUS_CNT_MSB:STATUS_CNT_LSB] = cnt;
    s[STATUS_OUT_MSB:STATUS_OUT_LSB] = outstanding;
    s[STATUS_ERR_MSB:STATUS_ERR_LSB] = err_cnt;
    s[STATUS_BUSY_BIT]               = busy;
    return s;
  endfunction

endpackage

// File: rtl/serial_link_tx_streamer_fifo.sv
// rtl/serial_link_tx_streamer_fifo.sv - registered-output TX FIFO (fifo_v3 behaviour, no fall-through)
module serial_link_tx_streamer_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = PtrWidth + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push,
  input  logic [Width-1:0]    wdata,
  input  logic                pop,
  output logic [Width-1:0]    rdata,
  output logic                full,
  output logic                empty,
  output logic [CntWidth-1:0] count
);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] rd_ptr;
  logic [PtrWidth-1:0] wr_ptr;
  logic [CntWidth-1:0] cnt;
  logic                do_push;
  logic                do_pop;

  assign full    = (cnt == CntWidth'(Depth));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      if (do_push && !do_pop)      cnt <= cnt + CntWidth'(1);
      else if (!do_push && do_pop) cnt <= cnt - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/serial_link_tx_streamer.sv
// rtl/serial_link_tx_streamer.sv - OBI register window that drains words as single-beat AXI4 writes
// Error counter and irq_error_o exist only when SL_TX_STREAMER_ERR_IRQ_EN is defined.
module serial_link_tx_streamer
  import serial_link_tx_streamer_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned FifoDepth      = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter type axi_req_t  = sl_axi_req_t,
  parameter type axi_rsp_t  = sl_axi_rsp_t,
  parameter type obi_req_t  = sl_obi_req_t,
  parameter type obi_resp_t = sl_obi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_rsp_o,
  output axi_req_t  axi_req_o,
  input  axi_rsp_t  axi_rsp_i,
  output logic      fifo_empty_o,
  output logic      fifo_full_o,
  output logic      busy_o,
  output logic      irq_error_o
);

  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam int unsigned EntryWidth = DataWidth + StrbWidth;
  localparam int unsigned CntWidth   = $clog2(FifoDepth) + 1;

  state_e                 state_q;
  logic                   enable_q;
  logic                   incr_q;
  logic [AddrWidth-1:0]   dst_addr_q;
  logic [AddrWidth-1:0]   aw_addr_q;
  logic                   dst_wr_pending_q;
  logic                   aw_valid_q;
  logic                   w_valid_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic [7:0]             outstanding_q;
  logic [7:0]             err_cnt;
  logic                   irq_error;
  logic                   rvalid_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [DataWidth-1:0]   rdata_d;

  logic [1:0]             reg_sel;
  logic                   data_wr;
  logic                   gnt;
  logic                   acc_wr;
  logic                   ctrl_wr;
  logic                   dst_wr;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   b_hs;
  logic                   issue_done;
  logic                   can_issue;
  logic                   busy;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [EntryWidth-1:0]  fifo_rdata;
  logic [CntWidth-1:0]    fifo_cnt;

  assign reg_sel = obi_req_i.addr[3:2];
  assign data_wr = obi_req_i.req & obi_req_i.we & (reg_sel == REG_DATA);
  // A full FIFO stalls DATA writes even if a pop happens this cycle.
  assign gnt     = obi_req_i.req & ~(data_wr & fifo_full);
  assign acc_wr  = gnt & obi_req_i.we;
  assign ctrl_wr = acc_wr & (reg_sel == REG_CTRL);
  assign dst_wr  = acc_wr & (reg_sel == REG_DST_ADDR);

  assign aw_hs      = aw_valid_q & axi_rsp_i.aw_ready;
  assign w_hs       = w_valid_q & axi_rsp_i.w_ready;
  assign b_hs       = axi_rsp_i.b_valid;
  assign issue_done = (state_q == SEND) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign can_issue  = (state_q == IDLE) & enable_q & ~fifo_empty
                      & (outstanding_q < 8'(MaxOutstanding));
  assign busy       = ~fifo_empty | (state_q == SEND) | (outstanding_q != '0);

  serial_link_tx_streamer_fifo #(
    .Width (EntryWidth),
    .Depth (FifoDepth)
  ) i_tx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (data_wr & ~fifo_full),
    .wdata  ({obi_req_i.wdata[DataWidth-1:0], obi_req_i.be[StrbWidth-1:0]}),
    .pop    (issue_done),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            state_q    <= SEND;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_addr_q  <= dst_addr_q;
          end
        end
        SEND: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if (issue_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Software writing DST_ADDR while a beat is in flight wins over the auto-increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q         <= 1'b0;
      incr_q           <= 1'b0;
      dst_addr_q       <= '0;
      dst_wr_pending_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= obi_req_i.wdata[CTRL_ENABLE];
        incr_q   <= obi_req_i.wdata[CTRL_INCR];
      end
      if (dst_wr) begin
        dst_addr_q <= obi_req_i.wdata[AddrWidth-1:0];
      end else if (issue_done && incr_q && !dst_wr_pending_q) begin
        dst_addr_q <= aw_addr_q + AddrWidth'(4);
      end
      if (can_issue)   dst_wr_pending_q <= dst_wr;
      else if (dst_wr) dst_wr_pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      if (issue_done && !b_hs) begin
        outstanding_q <= outstanding_q + 8'd1;
      end else if (!issue_done && b_hs && (outstanding_q != '0)) begin
        outstanding_q <= outstanding_q - 8'd1;
      end
    end
  end

`ifdef SL_TX_STREAMER_ERR_IRQ_EN
  logic b_err;
  logic err_clr;
  logic [7:0] err_cnt_q;
  logic       irq_error_q;

  assign b_err   = b_hs & (axi_rsp_i.b.resp != AXI_RESP_OKAY);
  assign err_clr = ctrl_wr & obi_req_i.wdata[CTRL_ERR_CLR];

  // An error arriving with the clear is kept rather than lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q   <= '0;
      irq_error_q <= 1'b0;
    end else if (err_clr) begin
      err_cnt_q   <= {7'd0, b_err};
      irq_error_q <= b_err;
    end else if (b_err) begin
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      irq_error_q <= 1'b1;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign irq_error = irq_error_q;
`else
  assign err_cnt   = '0;
  assign irq_error = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      REG_DATA:     rdata_d = '0;
      REG_DST_ADDR: rdata_d = DataWidth'(dst_addr_q);
      REG_STATUS:   rdata_d = DataWidth'(pack_status(8'(fifo_cnt), outstanding_q, err_cnt, busy));
      REG_CTRL:     rdata_d = DataWidth'({incr_q, enable_q});
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      rdata_q  <= (gnt && !obi_req_i.we) ? rdata_d : '0;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = gnt;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = '0;
    axi_req_o.aw.addr  = aw_addr_q;
    axi_req_o.aw.len   = '0;
    axi_req_o.aw.size  = 3'd2;
    axi_req_o.aw.burst = AXI_BURST_INCR;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = fifo_rdata[EntryWidth-1:StrbWidth];
    axi_req_o.w.strb   = fifo_rdata[StrbWidth-1:0];
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = 1'b1;
    axi_req_o.ar_valid = 1'b0;
    axi_req_o.r_ready  = 1'b1;
  end

  assign fifo_empty_o = fifo_empty;
  assign fifo_full_o  = fifo_full;
  assign busy_o       = busy;
  assign irq_error_o  = irq_error;

  logic unused_inputs;
  assign unused_inputs = ^{obi_req_i.addr[AddrWidth-1:4], obi_req_i.addr[1:0],
                           axi_rsp_i.ar_ready, axi_rsp_i.r_valid, axi_rsp_i.r,
                           axi_rsp_i.b.id, axi_rsp_i.b.resp};

endmodule

// File: tb/tb_serial_link_tx_streamer.sv
// tb/tb_serial_link_tx_streamer.sv - scoreboard bench for the serial link TX streamer
module tb_serial_link_tx_streamer;
  import serial_link_tx_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sl_obi_req_t  obi_req;
  sl_obi_resp_t obi_rsp;
  sl_axi_req_t  axi_req;
  sl_axi_rsp_t  axi_rsp;
  logic fifo_empty, fifo_full, busy, irq;

  logic        req_d = 1'b0, we_d = 1'b0;
  logic [31:0] addr_d = '0, wdata_d = '0;
  logic [3:0]  be_d = '0;
  logic        aw_ready = 1'b1, w_ready = 1'b1, b_valid = 1'b0;
  logic [1:0]  b_resp = 2'b00;

  always_comb begin
    obi_req       = '0;
    obi_req.req   = req_d;
    obi_req.we    = we_d;
    obi_req.addr  = addr_d;
    obi_req.be    = be_d;
    obi_req.wdata = wdata_d;
  end

  always_comb begin
    axi_rsp          = '0;
    axi_rsp.aw_ready = aw_ready;
    axi_rsp.w_ready  = w_ready;
    axi_rsp.b_valid  = b_valid;
    axi_rsp.b.resp   = b_resp;
  end

  serial_link_tx_streamer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .obi_req_i    (obi_req),
    .obi_rsp_o    (obi_rsp),
    .axi_req_o    (axi_req),
    .axi_rsp_i    (axi_rsp),
    .fifo_empty_o (fifo_empty),
    .fifo_full_o  (fifo_full),
    .busy_o       (busy),
    .irq_error_o  (irq)
  );

`ifdef SL_TX_STREAMER_ERR_IRQ_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];
  logic [32:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [1:0]  bresp_q[$];
  int aw_cnt = 0, w_cnt = 0, pairs = 0, pending_b = 0;
  bit b_en = 1'b1;
  logic [31:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  // Monitor: every AXI handshake and OBI rvalid is matched against the scoreboard queues.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [35:0] ew;
    logic [32:0] er;
    string       nm;
    if (rst_n) begin
      if (axi_req.aw_valid && aw_ready) begin
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else begin
          ea = exp_aw_q.pop_front();
          check("aw_addr", axi_req.aw.addr, ea);
          check("aw_attr", {axi_req.aw.id, axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst},
                {4'd0, 8'd0, 3'd2, 2'b01});
        end
        aw_cnt++;
      end
      if (axi_req.w_valid && w_ready) begin
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else begin
          ew = exp_w_q.pop_front();
          check("w_data", axi_req.w.data, ew[35:4]);
          check("w_strb_last", {axi_req.w.strb, axi_req.w.last}, {ew[3:0], 1'b1});
        end
        w_cnt++;
      end
      while (pairs < ((aw_cnt < w_cnt) ? aw_cnt : w_cnt)) begin
        pairs++;
        pending_b++;
      end
      if (obi_rsp.rvalid) begin
        if (exp_rd_q.size() == 0) fail_now("rvalid_unexpected");
        else begin
          er = exp_rd_q.pop_front();
          nm = rd_name_q.pop_front();
          if (er[32]) check(nm, obi_rsp.rdata, er[31:0]);
        end
      end
    end
  end

  // B responder: one response per completed AW+W pair, SLVERR codes taken from bresp_q.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      b_valid = 1'b0;
    end else if (b_en && pending_b > 0) begin
      b_valid = 1'b1;
      b_resp  = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
      pending_b--;
    end else begin
      b_valid = 1'b0;
      b_resp  = 2'b00;
    end
  end

  task automatic obi_xfer(input logic we, input logic [3:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                          input string name);
    int n = 0;
    @(posedge clk); #1;
    req_d = 1'b1; we_d = we; addr_d = {28'd0, addr}; be_d = be; wdata_d = wdata;
    @(negedge clk);
    while (!obi_rsp.gnt && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!obi_rsp.gnt) fail_now({name, "_gnt_timeout"});
    else begin
      exp_rd_q.push_back({chk, exp});
      rd_name_q.push_back(name);
    end
    @(posedge clk); #1;
    req_d = 1'b0; we_d = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
    obi_xfer(1'b1, addr, 4'hF, data, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd_reg(input logic [3:0] addr, input logic [31:0] exp, input string name);
    obi_xfer(1'b0, addr, 4'hF, 32'd0, 1'b1, exp, name);
  endtask

  task automatic push_word(input logic [31:0] data, input logic [3:0] be);
    exp_aw_q.push_back(exp_addr);
    exp_addr += 32'd4;
    exp_w_q.push_back({data, be});
    obi_xfer(1'b1, 4'h0, be, data, 1'b1, 32'd0, "data_wr_rdata");
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_aw_q.size() != 0 || exp_w_q.size() != 0 || pending_b != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now({name, "_idle_timeout"});
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_aw_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!axi_req.aw_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!axi_req.aw_valid) fail_now({name, "_aw_timeout"});
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    check("rst_gnt_rvalid", {obi_rsp.gnt, obi_rsp.rvalid}, 2'b00);
    check("rst_rdata", obi_rsp.rdata, 32'd0);
    check("rst_awv_wv", {axi_req.aw_valid, axi_req.w_valid}, 2'b00);
    check("rst_flags", {fifo_empty, fifo_full, busy, irq}, 4'b1000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word: DATA granted at t gives aw_valid from t+2.
    wr_reg(4'hC, 32'h3);
    wr_reg(4'h4, 32'h1000);
    exp_addr = 32'h1000;
    push_word(32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    check("t1_awv_t1", axi_req.aw_valid, 1'b0);
    @(negedge clk);
    check("t1_awv_wv_t2", {axi_req.aw_valid, axi_req.w_valid}, 2'b11);
    wait_idle("t1");
    rd_reg(4'h8, 32'h0, "t1_status");
    rd_reg(4'h4, 32'h1004, "t1_dst");
    rd_reg(4'h0, 32'h0, "t1_data_rd");
    rd_reg(4'hC, 32'h3, "t1_ctrl");

    // Fill the FIFO with ENABLE clear, then watch the ninth DATA write stall.
    wr_reg(4'hC, 32'h2);
    for (int i = 0; i < 8; i++) push_word(32'h1000_0000 + i, (i % 2 == 0) ? 4'hF : 4'h3);
    @(negedge clk);
    check("t2_full_empty", {fifo_full, fifo_empty}, 2'b10);
    rd_reg(4'h8, 32'h0100_0008, "t2_status_full");
    @(posedge clk); #1;
    req_d = 1'b1; we_d = 1'b1; addr_d = 32'h0; be_d = 4'hF; wdata_d = 32'hDEAD_0009;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_gnt_held_low", obi_rsp.gnt, 1'b0);
    end
    @(posedge clk); #1;
    req_d = 1'b0; we_d = 1'b0;
    wr_reg(4'hC, 32'h3);
    push_word(32'hDEAD_0009, 4'hF);
    wait_idle("t2");
    rd_reg(4'h4, 32'h1028, "t2_dst");

    // Outstanding limit with B held back.
    b_en = 1'b0;
    base = aw_cnt;
    for (int i = 0; i < 6; i++) push_word(32'h3000_0000 + i, 4'hF);
    repeat (20) @(negedge clk);
    check("t3_aw_limited", aw_cnt - base, 32'd4);
    rd_reg(4'h8, 32'h0100_0402, "t3_status");
    b_en = 1'b1;
    wait_idle("t3");
    check("t3_aw_total", aw_cnt - base, 32'd6);

    // AW accepted three cycles late while W goes through at once.
    aw_ready = 1'b0;
    push_word(32'h4444_0000, 4'h5);
    wait_aw_valid("t4");
    check("t4_first_cycle", {axi_req.aw_valid, axi_req.w_valid}, 2'b11);
    @(negedge clk);
    check("t4_w_dropped", {axi_req.aw_valid, axi_req.w_valid, fifo_empty}, 3'b100);
    @(negedge clk);
    check("t4_aw_held", {axi_req.aw_valid, fifo_empty}, 2'b10);
    @(posedge clk); #1;
    aw_ready = 1'b1;
    @(negedge clk);
    check("t4_aw_hs_cycle", {axi_req.aw_valid, fifo_empty}, 2'b10);
    @(negedge clk);
    check("t4_popped_once", {axi_req.aw_valid, fifo_empty, busy}, 3'b011);
    wait_idle("t4");
    rd_reg(4'h8, 32'h0, "t4_status");

    // Error responses and the CTRL clear bit.
    bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b10);
    push_word(32'h5555_0001, 4'hF);
    push_word(32'h5555_0002, 4'hF);
    wait_idle("t5");
    rd_reg(4'h8, ErrEn ? 32'h0002_0000 : 32'h0, "t5_status_err");
    check("t5_irq_set", irq, ErrEn);
    wr_reg(4'hC, 32'h4);
    @(negedge clk);
    check("t5_irq_cleared", irq, 1'b0);
    rd_reg(4'h8, 32'h0, "t5_status_clr");
    rd_reg(4'hC, 32'h0, "t5_ctrl");
    wr_reg(4'hC, 32'h3);

    // Reset asserted in the middle of a SEND.
    aw_ready = 1'b0;
    push_word(32'h6666_0000, 4'hF);
    wait_aw_valid("t6");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valids", {axi_req.aw_valid, axi_req.w_valid}, 2'b00);
    check("t6_rst_flags", {fifo_empty, fifo_full, busy, irq}, 4'b1000);
    exp_aw_q.delete();
    exp_w_q.delete();
    aw_cnt = 0; w_cnt = 0; pairs = 0; pending_b = 0;
    aw_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_reg(4'h4, 32'h0, "t6_dst");
    rd_reg(4'hC, 32'h0, "t6_ctrl");
    rd_reg(4'h8, 32'h0, "t6_status");
    repeat (4) @(negedge clk);
    check("end_queues_empty", exp_aw_q.size() + exp_w_q.size() + exp_rd_q.size(), 32'd0);
    check("end_no_aw", aw_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
